bl_mux_scanner: RTL and testbench
=================================

# bl_mux_scanner

Sequencer that drives the 4-bit bit-line mux control word {EN, A2, A1, A0} through a masked set of channels in ascending order. Per channel it inserts a break-before-make gap, waits a programmable settle time, and requests one sample from the downstream sampler over a req/ack handshake. It returns each sample tagged with its channel. It sits upstream of the bit-line mux: its `control_signal` output feeds the mux's control input, and it collects the readings of the selected line.

## Interface
- `SETTLE_CYCLES`, 16: cycles with EN=1 before a sample is requested; legal range 1..255.
- `DATA_WIDTH`, 12: width of sample data.

- `Clock`  in  1  : single clock; all logic rising-edge.
- `Reset`  in  1  : asynchronous, active-high; clears all state.
- `start`  in  1  : single-cycle request to begin a scan; ignored while `busy`=1.
- `abort`  in  1  : terminate the scan in progress.
- `ch_mask`  in  8  : channels to visit (bit n = channel n); captured on accepted `start`.
- `control_signal`  out  4  : [3]=EN, [2:0]=A2..A0 to the bit-line mux; registered.
- `sample_req`  out  1  : sample request to the sampler.
- `sample_ack`  in  1  : sampler handshake; `sample_data` is valid in the same cycle.
- `sample_data`  in  DATA_WIDTH  : sampled value.
- `result_valid`  out  1  : one-cycle pulse; result outputs are valid.
- `result_ch`  out  3  : channel of the result.
- `result_data`  out  DATA_WIDTH  : captured sample.
- `busy`  out  1  : high from the cycle after an accepted `start` until the return to IDLE.
- `done`  out  1  : one-cycle pulse at normal scan completion.

## Operation
- States:
  - IDLE: EN=0, address held.
  - SELECT: EN=0, new address driven.
  - SETTLE: EN=1, counter running.
  - SAMPLE: EN=1, `sample_req`=1.
  - DONE: `done`=1, EN=0.
- IDLE→SELECT on `start` with nonzero mask. The address is the lowest set bit of the mask; the mask is latched.
- IDLE→DONE on `start` with mask==0. The mux is never enabled.
- SELECT→SETTLE after 1 cycle. This is the break-before-make gap: the address changes only while EN=0.
- SETTLE→SAMPLE after exactly SETTLE_CYCLES cycles in SETTLE.
- SAMPLE: `sample_req` stays high until `sample_ack`=1. There is no timeout.
  - On ack, `sample_data` and the current channel are registered.
  - Next state is SELECT (lowest set mask bit above the current channel) or DONE (no such bit).
- DONE→IDLE after 1 cycle.
- `sample_ack` is ignored outside SAMPLE.
- `abort` in any non-IDLE state:
  - Next cycle is IDLE: EN=0, `sample_req`=0, `busy`=0.
  - No `done`. No `result_valid` for the in-flight channel, even if `ack` and `abort` arrive in the same cycle.
- `start` together with `abort` in IDLE: `abort` wins and `start` is dropped.
- Address bits hold their last value when EN=0, except in SELECT.

## Timing
- Reset values:
  - `control_signal`=4'b0000.
  - `sample_req`, `result_valid`, `busy`, `done` = 0.
  - `result_ch`=0, `result_data`=0.
  - State is IDLE, latched mask = 0.
- Let an accepted `start` be sampled at edge k:
  - Cycle k+1: SELECT, `busy`=1, EN=0.
  - Cycles k+2 .. k+1+S: EN=1 (S = SETTLE_CYCLES).
  - From k+2+S: `sample_req`=1.
- `ack` sampled at edge e:
  - Cycle e+1: `sample_req`=0, `result_valid`=1, and the state is SELECT of the next channel or DONE.
- Per-channel minimum: 1 + S + 1 cycles, i.e. zero-wait ack.
- Mask==0: `done` in cycle k+1, `busy`=1 only in that cycle.
- `Reset` asserted mid-scan forces all outputs to their reset values immediately (asynchronous). Operation resumes on the first edge after deassertion.

## Structure
- Shared package `bl_mux_pkg`:
  - State enum.
  - `NUM_CH`=8.
  - Control word bit positions: `EN_BIT`=3, `ADDR_MSB`=2, `ADDR_LSB`=0.
  - The package is shared with the mux side so the control word layout is defined once.
- Sub-module `bl_next_ch`: combinational priority finder. Inputs are the 8-bit mask and the 3-bit current channel plus a "first" flag. Outputs are `found` and the 3-bit next channel.
- Settle counter: 8-bit down-counter inside `bl_mux_scanner`.

## Test plan (SETTLE_CYCLES=4)
- mask=8'hFF, zero-wait ack:
  - 8 `result_valid` pulses with `result_ch` 0..7 in order, `result_data` equal to the acked data.
  - `done` 6 cycles after the 8th SELECT cycle, i.e. in the cycle of the 8th result.
  - EN=1 for exactly 5 cycles per channel.
- mask=8'b1010_0100: channels 2, 5, 7 only.
  - Every address change occurs in a cycle with EN=0; EN never rises on channels 0, 1, 3, 4, 6.
- mask=0: `done`=1 the cycle after `start`, EN never 1, no `result_valid`.
- Ack delayed 10 cycles on channel 3: `sample_req` held 10 cycles with EN=1 and the address stable; `result_valid` the cycle after ack. Also apply `start` pulses while busy → ignored.
- `abort` while in SETTLE of channel 1 (mask=8'h0F) → next cycle EN=0, `busy`=0, no `done`. `abort` coincident with `ack` → no `result_valid`.
- `Reset` asserted asynchronously mid-SAMPLE → `control_signal`=0 and `sample_req`=0 before the next edge. A new `start` after release scans from the lowest set bit.

Source files
------------

// File: rtl/bl_mux_pkg.sv
// Shared definitions for the bit-line mux scanner and the mux side.
// Control word layout is defined here once: {EN, A2, A1, A0}.
package bl_mux_pkg;

   localparam int NUM_CH   = 8;
   localparam int EN_BIT   = 3;
   localparam int ADDR_MSB = 2;
   localparam int ADDR_LSB = 0;
   localparam int CH_W     = ADDR_MSB - ADDR_LSB + 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   function automatic logic [EN_BIT:0] ctrl_word(
      input logic            en,
      input logic [CH_W-1:0] addr
   );
      logic [EN_BIT:0] w;
      w                    = '0;
      w[EN_BIT]            = en;
      w[ADDR_MSB:ADDR_LSB] = addr;
      return w;
   endfunction

endpackage

// File: rtl/bl_mux_scanner_next_ch.sv
// Priority finder: lowest set mask bit, either from channel 0
// (first) or strictly above the current channel.
module bl_next_ch
   import bl_mux_pkg::*;
(
   input  logic [NUM_CH-1:0] i_mask,
   input  logic [CH_W-1:0]   i_cur,
   input  logic              i_first,
   output logic              o_found,
   output logic [CH_W-1:0]   o_ch
);

   // Descending sweep so the lowest qualifying bit is the last write.
   always_comb begin
      o_found = 1'b0;
      o_ch    = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (i_mask[i] && (i_first || i > int'(i_cur))) begin
            o_found = 1'b1;
            o_ch    = CH_W'(i);
         end
      end
   end

endmodule

// File: rtl/bl_mux_scanner.sv
// Scans masked bit-line mux channels with break-before-make,
// settle delay and a req/ack sample handshake per channel.
module bl_mux_scanner
   import bl_mux_pkg::*;
#(
   parameter int SETTLE_CYCLES = 16,
   parameter int DATA_WIDTH    = 12
)(
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [NUM_CH-1:0]     ch_mask,
   output logic [EN_BIT:0]       control_signal,
   output logic                  sample_req,
   input  logic                  sample_ack,
   input  logic [DATA_WIDTH-1:0] sample_data,
   output logic                  result_valid,
   output logic [CH_W-1:0]       result_ch,
   output logic [DATA_WIDTH-1:0] result_data,
   output logic                  busy,
   output logic                  done
);

   state_t                r_state;
   state_t                w_next;
   logic [NUM_CH-1:0]     r_mask;
   logic [NUM_CH-1:0]     w_fmask;
   logic [CH_W-1:0]       r_addr;
   logic [CH_W-1:0]       w_ch;
   logic                  w_found;
   logic                  w_first;
   logic                  w_load;
   logic                  w_ack;
   logic [7:0]            r_cnt;
   logic                  r_en;
   logic                  r_req;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_rv;
   logic [CH_W-1:0]       r_rch;
   logic [DATA_WIDTH-1:0] r_rdata;

   // In IDLE the search runs on the live mask so the first
   // address is ready in the SELECT cycle right after start.
   assign w_first = (r_state == ST_IDLE);
   assign w_fmask = w_first ? ch_mask : r_mask;

   bl_next_ch u_next (
      .i_mask  (w_fmask),
      .i_cur   (r_addr),
      .i_first (w_first),
      .o_found (w_found),
      .o_ch    (w_ch)
   );

   assign w_ack = (r_state == ST_SAMPLE) && sample_ack && !abort;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      if (abort) begin
         w_next = ST_IDLE;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (start) begin
                  w_load = 1'b1;
                  w_next = w_found ? ST_SELECT : ST_DONE;
               end
            end
            ST_SELECT: w_next = ST_SETTLE;
            ST_SETTLE: begin
               if (r_cnt == '0) w_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
               if (sample_ack) begin
                  w_next = w_found ? ST_SELECT : ST_DONE;
               end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_mask  <= '0;
         r_addr  <= '0;
         r_cnt   <= '0;
         r_en    <= 1'b0;
         r_req   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_rv    <= 1'b0;
         r_rch   <= '0;
         r_rdata <= '0;
      end else begin
         if (w_load) r_mask <= ch_mask;
         if (w_next == ST_SELECT) r_addr <= w_ch;
         if (r_state == ST_SELECT) begin
            r_cnt <= 8'(SETTLE_CYCLES - 1);
         end else if (r_state == ST_SETTLE && r_cnt != '0) begin
            r_cnt <= r_cnt - 8'd1;
         end
         r_en   <= (w_next == ST_SETTLE) || (w_next == ST_SAMPLE);
         r_req  <= (w_next == ST_SAMPLE);
         r_busy <= (w_next != ST_IDLE);
         r_done <= (w_next == ST_DONE);
         r_rv   <= w_ack;
         if (w_ack) begin
            r_rch   <= r_addr;
            r_rdata <= sample_data;
         end
      end
   end

   assign control_signal = ctrl_word(r_en, r_addr);
   assign sample_req     = r_req;
   assign busy           = r_busy;
   assign done           = r_done;
   assign result_valid   = r_rv;
   assign result_ch      = r_rch;
   assign result_data    = r_rdata;

endmodule

// File: tb/tb_bl_mux_scanner.sv
// Directed bench for bl_mux_scanner with SETTLE_CYCLES=4.
// Table of scans plus hand sequences for abort and reset.
module tb_bl_mux_scanner;

   localparam int S  = 4;
   localparam int DW = 12;

   logic          Clock = 1'b0;
   logic          Reset = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [7:0]    ch_mask = '0;
   logic [3:0]    control_signal;
   logic          sample_req;
   logic          sample_ack = 1'b0;
   logic [DW-1:0] sample_data = '0;
   logic          result_valid;
   logic [2:0]    result_ch;
   logic [DW-1:0] result_data;
   logic          busy;
   logic          done;

   int n_tests = 0;
   int n_fail  = 0;
   logic [2:0] last_addr = '0;

   typedef struct {
      logic [7:0]  mask;
      int          n;
      logic [23:0] chs;
      int          wch;
      int          wn;
   } vec_t;

   vec_t vt[7];

   bl_mux_scanner #(
      .SETTLE_CYCLES (S),
      .DATA_WIDTH    (DW)
   ) dut (
      .Clock          (Clock),
      .Reset          (Reset),
      .start          (start),
      .abort          (abort),
      .ch_mask        (ch_mask),
      .control_signal (control_signal),
      .sample_req     (sample_req),
      .sample_ack     (sample_ack),
      .sample_data    (sample_data),
      .result_valid   (result_valid),
      .result_ch      (result_ch),
      .result_data    (result_data),
      .busy           (busy),
      .done           (done)
   );

   always #5 Clock = ~Clock;

   function automatic logic [7:0] obs();
      return {result_valid, done, busy, sample_req, control_signal};
   endfunction

   function automatic logic [7:0] ex(
      input logic rv, input logic dn, input logic bs,
      input logic rq, input logic en, input logic [2:0] a
   );
      return {rv, dn, bs, rq, en, a};
   endfunction

   task automatic chk(
      input string nm, input logic [31:0] act, input logic [31:0] exp
   );
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic run_scan(input vec_t v, input int idx);
      logic [2:0]    ch;
      logic [2:0]    nx;
      logic [DW-1:0] d;
      @(negedge Clock);
      start   = 1'b1;
      ch_mask = v.mask;
      @(negedge Clock);
      start = 1'b0;
      if (v.n == 0) begin
         chk("zero_done", obs(), ex(0, 1, 1, 0, 0, last_addr));
         @(negedge Clock);
         chk("zero_idle", obs(), ex(0, 0, 0, 0, 0, last_addr));
         @(negedge Clock);
         chk("zero_quiet", obs(), ex(0, 0, 0, 0, 0, last_addr));
         return;
      end
      ch = v.chs[2:0];
      chk("select", obs(), ex(0, 0, 1, 0, 0, ch));
      for (int i = 0; i < v.n; i++) begin
         ch = v.chs[3*i +: 3];
         for (int j = 0; j < S; j++) begin
            @(negedge Clock);
            chk("settle", obs(), ex(0, 0, 1, 0, 1, ch));
            sample_ack = (j == 0);
         end
         @(negedge Clock);
         chk("req", obs(), ex(0, 0, 1, 1, 1, ch));
         if (int'(ch) == v.wch) begin
            for (int w = 1; w < v.wn; w++) begin
               start   = (w % 2 == 1);
               ch_mask = 8'hFF;
               @(negedge Clock);
               chk("hold", obs(), ex(0, 0, 1, 1, 1, ch));
            end
            start = 1'b0;
         end
         d = DW'(32'h5A0 + idx * 37 + i * 3);
         sample_ack  = 1'b1;
         sample_data = d;
         @(negedge Clock);
         sample_ack = 1'b0;
         if (i == v.n - 1) begin
            chk("last", obs(), ex(1, 1, 1, 0, 0, ch));
         end else begin
            nx = v.chs[3*(i+1) +: 3];
            chk("next", obs(), ex(1, 0, 1, 0, 0, nx));
         end
         chk("rch", 32'(result_ch), 32'(ch));
         chk("rdata", 32'(result_data), 32'(d));
      end
      @(negedge Clock);
      chk("idle", obs(), ex(0, 0, 0, 0, 0, ch));
      last_addr = ch;
   endtask

   initial begin
      vt[0] = '{8'hFF, 8,
                {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
                -1, 0};
      vt[1] = '{8'hA4, 3, {15'd0, 3'd7, 3'd5, 3'd2}, -1, 0};
      vt[2] = '{8'h00, 0, 24'd0, -1, 0};
      vt[3] = '{8'h0A, 2, {18'd0, 3'd3, 3'd1}, 3, 10};
      vt[4] = '{8'h80, 1, {21'd0, 3'd7}, -1, 0};
      vt[5] = '{8'h01, 1, {21'd0, 3'd0}, -1, 0};
      vt[6] = '{8'h24, 2, {18'd0, 3'd5, 3'd2}, -1, 0};

      #1;
      chk("rst_obs", obs(), 8'h00);
      chk("rst_rch", 32'(result_ch), 32'd0);
      chk("rst_rdata", 32'(result_data), 32'd0);
      @(negedge Clock);
      Reset = 1'b0;

      for (int k = 0; k < 6; k++) run_scan(vt[k], k);

      // abort during first SETTLE cycle of channel 1
      @(negedge Clock);
      start   = 1'b1;
      ch_mask = 8'h0F;
      @(negedge Clock);
      start = 1'b0;
      chk("ab_sel0", obs(), ex(0, 0, 1, 0, 0, 0));
      repeat (S) @(negedge Clock);
      @(negedge Clock);
      chk("ab_req0", obs(), ex(0, 0, 1, 1, 1, 0));
      sample_ack  = 1'b1;
      sample_data = 12'h123;
      @(negedge Clock);
      sample_ack = 1'b0;
      chk("ab_sel1", obs(), ex(1, 0, 1, 0, 0, 1));
      @(negedge Clock);
      chk("ab_set1", obs(), ex(0, 0, 1, 0, 1, 1));
      abort = 1'b1;
      @(negedge Clock);
      abort = 1'b0;
      chk("ab_idle", obs(), ex(0, 0, 0, 0, 0, 1));
      repeat (3) begin
         @(negedge Clock);
         chk("ab_quiet", obs(), ex(0, 0, 0, 0, 0, 1));
      end

      // abort coincident with ack
      @(negedge Clock);
      start   = 1'b1;
      ch_mask = 8'h0F;
      @(negedge Clock);
      start = 1'b0;
      chk("aa_sel0", obs(), ex(0, 0, 1, 0, 0, 0));
      repeat (S) @(negedge Clock);
      @(negedge Clock);
      chk("aa_req0", obs(), ex(0, 0, 1, 1, 1, 0));
      sample_ack  = 1'b1;
      sample_data = 12'h456;
      abort       = 1'b1;
      @(negedge Clock);
      sample_ack = 1'b0;
      abort      = 1'b0;
      chk("aa_idle", obs(), ex(0, 0, 0, 0, 0, 0));
      chk("aa_rdata", 32'(result_data), 32'h123);

      // start and abort together in IDLE
      @(negedge Clock);
      start   = 1'b1;
      abort   = 1'b1;
      ch_mask = 8'hFF;
      @(negedge Clock);
      start = 1'b0;
      abort = 1'b0;
      chk("sa_drop", obs(), ex(0, 0, 0, 0, 0, 0));
      @(negedge Clock);
      chk("sa_quiet", obs(), ex(0, 0, 0, 0, 0, 0));

      // asynchronous reset in SAMPLE of channel 2
      @(negedge Clock);
      start   = 1'b1;
      ch_mask = 8'h24;
      @(negedge Clock);
      start = 1'b0;
      chk("rs_sel", obs(), ex(0, 0, 1, 0, 0, 2));
      repeat (S) @(negedge Clock);
      @(negedge Clock);
      chk("rs_req", obs(), ex(0, 0, 1, 1, 1, 2));
      Reset = 1'b1;
      #1;
      chk("rs_async", obs(), 8'h00);
      chk("rs_rdata", 32'(result_data), 32'd0);
      @(negedge Clock);
      Reset     = 1'b0;
      last_addr = '0;
      run_scan(vt[6], 6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
